// File: rtl/sha3_rr_arbiter.sv
// sha3_rr_arbiter: message-granular two-way round-robin arbiter in front of one SHA3-256 core.
//   clk, rst_n                  : system clock, asynchronous active-low reset
//   reqN_in_data/valid/done     : message words and end-of-message marker from requester N
//   reqN_in_ready               : word/done accepted from requester N (only while it owns the core)
//   reqN_out_data/valid/ready   : digest words towards requester N
//   core_in_* / core_out_*      : word interfaces of the shared core
//   grant                       : one-hot owner, 00 when idle
//   busy                        : arbiter is not idle
//   msg_count                   : completed messages, wraps
module sha3_rr_arbiter #(
    parameter int DATA_W       = 32,
    parameter int DIGEST_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] req0_in_data,
    input  logic              req0_in_valid,
    input  logic              req0_in_done,
    output logic              req0_in_ready,
    input  logic [DATA_W-1:0] req1_in_data,
    input  logic              req1_in_valid,
    input  logic              req1_in_done,
    output logic              req1_in_ready,
    output logic [DATA_W-1:0] req0_out_data,
    output logic              req0_out_valid,
    input  logic              req0_out_ready,
    output logic [DATA_W-1:0] req1_out_data,
    output logic              req1_out_valid,
    input  logic              req1_out_ready,
    output logic [DATA_W-1:0] core_in_data,
    output logic              core_in_valid,
    output logic              core_in_done,
    input  logic              core_in_ready,
    input  logic [DATA_W-1:0] core_out_data,
    input  logic              core_out_valid,
    output logic              core_out_ready,
    output logic [1:0]        grant,
    output logic              busy,
    output logic [15:0]       msg_count
);
    localparam int CW = $clog2(DIGEST_WORDS) + 1;

    typedef enum logic [1:0] {IDLE, ABSORB, SQUEEZE} state_t;

    state_t        state;
    logic          last;
    logic [CW-1:0] beat;
    logic          r0;
    logic          r1;
    logic          absorb;
    logic          squeeze;
    logic          sel;

    assign r0      = req0_in_valid | req0_in_done;
    assign r1      = req1_in_valid | req1_in_done;
    assign absorb  = state == ABSORB;
    assign squeeze = state == SQUEEZE;
    assign sel     = grant[1];
    assign busy    = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= 2'b00;
            last      <= 1'b1;
            beat      <= '0;
            msg_count <= '0;
        end else begin
            case (state)
                IDLE:
                    if (r0 | r1) begin
                        state <= ABSORB;
                        // on a tie, requester 0 wins only if requester 1 owned the core last
                        if (r0 & (!r1 | last)) begin
                            grant <= 2'b01;
                            last  <= 1'b0;
                        end else begin
                            grant <= 2'b10;
                            last  <= 1'b1;
                        end
                    end
                ABSORB:
                    if (core_in_done & core_in_ready) begin
                        state <= SQUEEZE;
                        beat  <= '0;
                    end
                SQUEEZE:
                    if (core_out_valid & core_out_ready) begin
                        if (beat == CW'(DIGEST_WORDS - 1)) begin
                            state     <= IDLE;
                            grant     <= 2'b00;
                            beat      <= '0;
                            msg_count <= msg_count + 16'd1;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                default: state <= IDLE;
            endcase
        end
    end

    // routing is purely combinational on registered state/grant: no added pipeline stage
    always_comb begin
        core_in_data   = absorb ? (sel ? req1_in_data : req0_in_data) : '0;
        core_in_valid  = absorb & (sel ? req1_in_valid : req0_in_valid);
        core_in_done   = absorb & (sel ? req1_in_done : req0_in_done);
        req0_in_ready  = absorb & grant[0] & core_in_ready;
        req1_in_ready  = absorb & grant[1] & core_in_ready;
        // core output is held off (not dropped) outside SQUEEZE
        core_out_ready = squeeze & (sel ? req1_out_ready : req0_out_ready);
        req0_out_valid = squeeze & grant[0] & core_out_valid;
        req1_out_valid = squeeze & grant[1] & core_out_valid;
        req0_out_data  = (squeeze & grant[0]) ? core_out_data : '0;
        req1_out_data  = (squeeze & grant[1]) ? core_out_data : '0;
    end
endmodule

// File: doc/sha3_rr_arbiter.md
# sha3_rr_arbiter

Two-requester, message-granular round-robin arbiter that shares one SHA3-256 wrapper core between two word-stream clients, e.g. the UART bridge and a second on-chip source. It sits between the requesters and the core's in/out word interfaces. It locks a grant for the full length of one message, from the first absorbed word through the last digest word drained. While a requester is not granted, the arbiter holds it off on both directions.

## Interface
Parameters:
- DATA_W, 32, word width of all data buses
- DIGEST_WORDS, 8, out beats per message (256-bit digest / DATA_W)

Ports:
- clk  in  1  single system clock
- rst_n  in  1  asynchronous active-low reset
- req0_in_data / req1_in_data  in  DATA_W  message word from requester n
- req0_in_valid / req1_in_valid  in  1  word valid
- req0_in_done / req1_in_done  in  1  end-of-message marker
- req0_in_ready / req1_in_ready  out  1  word/done accepted
- req0_out_data / req1_out_data  out  DATA_W  digest word
- req0_out_valid / req1_out_valid  out  1  digest word valid
- req0_out_ready / req1_out_ready  in  1  requester accepts digest word
- core_in_data  out  DATA_W  to core in_data
- core_in_valid, core_in_done  out  1  to core
- core_in_ready  in  1  from core
- core_out_data  in  DATA_W  from core
- core_out_valid  in  1  from core
- core_out_ready  out  1  to core
- grant  out  2  one-hot current owner, 00 when idle
- busy  out  1  state != IDLE
- msg_count  out  16  completed messages (all requesters), wraps 0xFFFF->0

## Operation
- States: IDLE, ABSORB, SQUEEZE.
- Request from requester n: in_valid | in_done.
- IDLE:
  - If exactly one requester requests, grant it.
  - If both request, grant the one that was not the last owner.
  - The last owner resets to requester 1, so requester 0 wins the first tie.
  - Grant and last-owner update on the registered transition to ABSORB.
- ABSORB:
  - core_in_{data,valid,done} = granted requester's signals.
  - Granted in_ready = core_in_ready.
  - Non-granted in_ready = 0.
  - A transfer occurs when (valid|done) & ready.
  - A transfer with done=1 ends the message, with or without valid in the same beat. Go to SQUEEZE and clear the beat counter.
- SQUEEZE:
  - Core in_* are driven 0.
  - Granted out_data/out_valid = core's.
  - core_out_ready = granted out_ready.
  - Count beats where core_out_valid & core_out_ready.
  - On beat DIGEST_WORDS, go to IDLE, clear grant and increment msg_count.
- Non-granted requester outputs: out_valid=0 and out_data=0 in every state.
- core_out_ready=0 outside SQUEEZE. Any core output in IDLE or ABSORB is held off, not dropped.
- Beat counter: $clog2(DIGEST_WORDS)+1 bits.
- Requester inputs that change while not granted are ignored. The arbiter has no buffering.

## Timing
- Reset values (async assert, sync release): state=IDLE, grant=00, busy=0, msg_count=0, last owner=1.
  - Both in_ready=0, both out_valid=0.
  - core_in_valid=0, core_in_done=0, core_out_ready=0.
  - All data outputs 0.
- Grant latency:
  - A request sampled in IDLE at cycle N gives grant/busy at N+1.
  - The earliest accepted word is at N+1, combinational through core_in_ready.
- All routing muxes are combinational on registered grant/state. The arbiter adds no datapath pipeline stage.
- Done transfer at cycle M sets state=SQUEEZE at M+1.
- The last digest beat at cycle K gives IDLE, grant=00 and msg_count+1 at K+1.
- The earliest re-grant is sampled at K+1, with grant at K+2.
- Back-pressure: out_ready low stalls SQUEEZE indefinitely. No timeout.
- Reset mid-message: everything returns to reset values immediately. The core is reset by the same rst_n.
- A request deasserted in the grant cycle keeps the grant. The arbiter waits in ABSORB for done.

## Test plan
- Single requester:
  - Stimulus: req0 sends 0x61626300, then done, with core model producing 8 words.
  - Required response: grant=01 one cycle after valid; all 8 words appear only on req0_out; msg_count=1; grant=00 after the 8th beat.
- Simultaneous requests from reset:
  - Stimulus: both raise in_valid in the same cycle.
  - Required response: req0 served first, then req1. The tie-break order alternates 0,1,0,1 over 4 back-to-back message pairs.
- Empty message:
  - Stimulus: req1 asserts in_done only.
  - Required response: core_in_done pulses with core_in_valid=0; SQUEEZE; 8 beats delivered to req1.
- Back-pressure:
  - Stimulus: req0_out_ready toggles 1-0-0-1 pattern.
  - Required response: no digest beat is lost or duplicated; the state exits SQUEEZE exactly after the 8th handshake.
- Isolation:
  - Stimulus: req1 holds in_valid and out_ready high during req0's message.
  - Required response: req1_in_ready=0, req1_out_valid=0 throughout; core sees only req0 data.
- Reset mid-SQUEEZE:
  - Stimulus: rst_n low after 3 digest beats.
  - Required response: all outputs reach reset values in the same cycle; msg_count=0; after release a new req1 message completes normally.
